// File: rtl/pic24_icsp_sender.sv
// PIC24 ICSP SIX-frame sender: reads a run of program-memory words and shifts
// each one out on PGC/PGD as a 4-bit 0000 command followed by a 24-bit instruction, LSB first.
module pic24_icsp_sender #(
    parameter int DATAWIDTH   = 32,
    parameter int MEMSIZElog2 = 7,
    parameter int CLKDIV      = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [MEMSIZElog2-1:0] base_addr,
    input  logic [MEMSIZElog2:0]   count,
    output logic                   busy,
    output logic                   done,
    output logic [MEMSIZElog2-1:0] mem_addr,
    output logic                   mem_ce,
    output logic                   mem_we,
    input  logic [DATAWIDTH-1:0]   mem_dout,
    output logic                   pgc,
    output logic                   pgd_out,
    output logic                   pgd_oe
);
    localparam int ADDRSIZE = 2 ** MEMSIZElog2;
    localparam int DIV_W    = $clog2(2 * CLKDIV) + 1;

    localparam logic [DIV_W-1:0]       DIV_HALF = DIV_W'(CLKDIV);
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(2 * CLKDIV - 1);
    localparam logic [DIV_W-1:0]       DIV_ONE  = DIV_W'(1);
    localparam logic [MEMSIZElog2:0]   CNT_MAX  = (MEMSIZElog2 + 1)'(ADDRSIZE);
    localparam logic [MEMSIZElog2:0]   CNT_ONE  = (MEMSIZElog2 + 1)'(1);
    localparam logic [MEMSIZElog2-1:0] ADDR_ONE = MEMSIZElog2'(1);
    localparam logic [4:0]             LAST_BIT = 5'd27;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [MEMSIZElog2-1:0] addr_reg;
    logic [MEMSIZElog2:0]   remaining_reg;
    logic [27:0]            shreg_reg;
    logic [4:0]             bit_cnt_reg;
    logic [DIV_W-1:0]       div_cnt_reg;
    logic                   pgd_out_reg;
    logic                   pgd_oe_reg;

    logic period_end;
    logic frame_end;
    logic last_word;

    assign period_end = (state_reg == SHIFT) && (div_cnt_reg == DIV_LAST);
    assign frame_end  = period_end && (bit_cnt_reg == LAST_BIT);
    assign last_word  = (remaining_reg == CNT_ONE);

    // Only the low 24 bits carry the instruction.
    generate
        if (DATAWIDTH > 24) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^mem_dout[DATAWIDTH-1:24];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (count == '0) ? DONE : FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (frame_end) state_next = last_word ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
            pgd_out_reg   <= 1'b0;
            pgd_oe_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg      <= base_addr;
                        remaining_reg <= (count > CNT_MAX) ? CNT_MAX : count;
                    end
                end
                LOAD: begin
                    shreg_reg   <= {mem_dout[23:0], 4'b0000};
                    bit_cnt_reg <= '0;
                    div_cnt_reg <= '0;
                    // Bit 0 of every frame is command bit 0, always zero.
                    pgd_out_reg <= 1'b0;
                    pgd_oe_reg  <= 1'b1;
                end
                SHIFT: begin
                    if (period_end) begin
                        div_cnt_reg <= '0;
                        shreg_reg   <= shreg_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        // Next bit is presented together with the next rising PGC.
                        if (!frame_end) pgd_out_reg <= shreg_reg[1];
                        if (frame_end) begin
                            remaining_reg <= remaining_reg - CNT_ONE;
                            if (last_word) pgd_oe_reg <= 1'b0;
                            else           addr_reg   <= addr_reg + ADDR_ONE;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_ONE;
                    end
                end
                DONE: begin
                    pgd_oe_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        done     = (state_reg == DONE);
        mem_ce   = (state_reg == FETCH);
        mem_we   = 1'b0;
        mem_addr = addr_reg;
        pgc      = (state_reg == SHIFT) && (div_cnt_reg < DIV_HALF);
        pgd_out  = pgd_out_reg;
        pgd_oe   = pgd_oe_reg;
    end

endmodule
